// File: rtl/dtpu_pkg.sv
// Shared DTPU definitions: weight-loader state encoding, default MXU
// geometry and a small sizing helper used by the loader.
package dtpu_pkg;

    // Weight-loader sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wl_state_t;

    // Default MXU geometry
    localparam int ROWS_DEFAULT               = 8;
    localparam int DATA_WIDTH_WMEMORY_DEFAULT = 64;

    // Width of a counter able to index n rows (at least one bit)
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mxu_weight_loader.sv
// MXU weight loader: streams ROWS consecutive weight-memory reads starting at
// a captured base address and steers each returned word into its MXU row with
// a one-hot write strobe. Completion is reported by a one-cycle pulse and a
// level flag that stays up until the control unit consumes the set.
//
// Optional build macro WLOADER_BOUNDS_CHECK_EN: when defined, a start whose
// weight set would extend past SIZE_WMEMORY is rejected (straight to DONE,
// no reads, sticky load_err). When undefined, addresses wrap and load_err
// is held at 0.
module mxu_weight_loader
    import dtpu_pkg::*;
#(
    parameter int ROWS               = ROWS_DEFAULT,
    parameter int DATA_WIDTH_WMEMORY = DATA_WIDTH_WMEMORY_DEFAULT,
    parameter int ADDR_WIDTH         = 32,
    parameter int SIZE_WMEMORY       = 8196
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          load_start,
    input  logic [ADDR_WIDTH-1:0]         load_base,
    input  logic                          weights_consumed,
    input  logic [DATA_WIDTH_WMEMORY-1:0] wm_dout,
    output logic [ADDR_WIDTH-1:0]         wm_address,
    output logic                          wm_ce,
    output logic                          wm_we,
    output logic [DATA_WIDTH_WMEMORY-1:0] row_data,
    output logic [ROWS-1:0]               row_sel,
    output logic                          row_we,
    output logic                          load_busy,
    output logic                          load_done,
    output logic                          weights_valid,
    output logic                          load_err
);

    localparam int               CNT_W    = cnt_width(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    wl_state_t               state_r;
    wl_state_t               state_next_s;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [CNT_W-1:0]        issue_cnt_r;
    logic [CNT_W-1:0]        wr_cnt_r;
    logic                    row_we_r;
    logic [ROWS-1:0]         row_sel_r;
    logic                    load_busy_r;
    logic                    load_done_r;
    logic                    weights_valid_r;
    logic                    load_err_r;
    logic                    accept_s;
    logic                    wm_ce_s;
    logic                    oob_s;

    // One-hot row strobe for a given write index
    function automatic logic [ROWS-1:0] row_onehot(input logic [CNT_W-1:0] idx);
        return ROWS'(1'b1) << idx;
    endfunction

    // Request acceptance in IDLE and the read strobe while issuing
    always_comb begin
        accept_s = (state_r == IDLE) && load_start && enable;
        wm_ce_s  = (state_r == ISSUE) && enable;
    end

`ifdef WLOADER_BOUNDS_CHECK_EN
    logic [ADDR_WIDTH:0] end_addr_s;

    // Flag a weight set that would run past the top of weight memory
    always_comb begin
        end_addr_s = {1'b0, load_base} + (ADDR_WIDTH + 1)'(ROWS);
        if (end_addr_s > (ADDR_WIDTH + 1)'(SIZE_WMEMORY)) begin
            oob_s = 1'b1;
        end else begin
            oob_s = 1'b0;
        end
    end
`else
    // No bounds check: addresses simply wrap
    always_comb begin
        oob_s = 1'b0;
    end
`endif

    // Next-state logic for the load sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (oob_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (wm_ce_s && (issue_cnt_r == LAST_ROW)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DRAIN:   state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Base capture and issue counter; a stalled cycle holds the count
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            base_r      <= {ADDR_WIDTH{1'b0}};
            issue_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            base_r      <= load_base;
            issue_cnt_r <= {CNT_W{1'b0}};
        end else if (wm_ce_s) begin
            issue_cnt_r <= issue_cnt_r + CNT_W'(1);
        end
    end

    // Write-back: every read strobe schedules a row write in the next cycle,
    // independent of enable, so an in-flight word is never dropped
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            row_we_r  <= 1'b0;
            row_sel_r <= {ROWS{1'b0}};
            wr_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            row_we_r <= wm_ce_s;
            if (accept_s) begin
                row_sel_r <= {ROWS{1'b0}};
                wr_cnt_r  <= {CNT_W{1'b0}};
            end else if (wm_ce_s) begin
                row_sel_r <= row_onehot(wr_cnt_r);
                wr_cnt_r  <= wr_cnt_r + CNT_W'(1);
            end else begin
                row_sel_r <= {ROWS{1'b0}};
            end
        end
    end

    // Status flags: busy/done track the state, valid set on a clean DONE
    // (winning over a same-cycle consume), error sticky until next accept
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            load_busy_r     <= 1'b0;
            load_done_r     <= 1'b0;
            weights_valid_r <= 1'b0;
            load_err_r      <= 1'b0;
        end else begin
            load_busy_r <= (state_next_s != IDLE);
            load_done_r <= (state_next_s == DONE);
            if (accept_s) begin
                weights_valid_r <= 1'b0;
            end else if ((state_r == DONE) && !load_err_r) begin
                weights_valid_r <= 1'b1;
            end else if (weights_consumed) begin
                weights_valid_r <= 1'b0;
            end
            if (accept_s) begin
                load_err_r <= oob_s;
            end
        end
    end

    assign wm_ce         = wm_ce_s;
    assign wm_address    = wm_ce_s ? (base_r + ADDR_WIDTH'(issue_cnt_r)) : {ADDR_WIDTH{1'b0}};
    assign wm_we         = 1'b0;
    assign row_we        = row_we_r;
    assign row_sel       = row_sel_r;
    assign row_data      = row_we_r ? wm_dout : {DATA_WIDTH_WMEMORY{1'b0}};
    assign load_busy     = load_busy_r;
    assign load_done     = load_done_r;
    assign weights_valid = weights_valid_r;
    assign load_err      = load_err_r;

endmodule

// File: tb/tb_mxu_weight_loader.sv
// Self-checking bench for mxu_weight_loader. A behavioural model tracks how
// many words have been issued and written for the current load and derives
// the expected read address, row strobe, row data and completion cycle.
module tb_mxu_weight_loader;

    localparam int ROWS = 8;
    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int SIZE = 8196;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            enable;
    logic            load_start;
    logic [AW-1:0]   load_base;
    logic            weights_consumed;
    logic [DW-1:0]   wm_dout;
    logic [AW-1:0]   wm_address;
    logic            wm_ce;
    logic            wm_we;
    logic [DW-1:0]   row_data;
    logic [ROWS-1:0] row_sel;
    logic            row_we;
    logic            load_busy;
    logic            load_done;
    logic            weights_valid;
    logic            load_err;

    int n_checks = 0;
    int n_pass   = 0;
    int d;

    always #5 clk = ~clk;

    mxu_weight_loader #(
        .ROWS(ROWS), .DATA_WIDTH_WMEMORY(DW), .ADDR_WIDTH(AW), .SIZE_WMEMORY(SIZE)
    ) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable), .load_start(load_start),
        .load_base(load_base), .weights_consumed(weights_consumed), .wm_dout(wm_dout),
        .wm_address(wm_address), .wm_ce(wm_ce), .wm_we(wm_we), .row_data(row_data),
        .row_sel(row_sel), .row_we(row_we), .load_busy(load_busy), .load_done(load_done),
        .weights_valid(weights_valid), .load_err(load_err)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8{a[7:0]}};
    endfunction

    // Weight memory: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        wm_dout <= wm_ce ? mem_word(wm_address) : 64'hDEAD_BEEF_0BAD_F00D;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wm_ce"}, 64'(wm_ce), 64'd0);
        check({tag, " wm_address"}, 64'(wm_address), 64'd0);
        check({tag, " wm_we"}, 64'(wm_we), 64'd0);
        check({tag, " row_we"}, 64'(row_we), 64'd0);
        check({tag, " row_sel"}, 64'(row_sel), 64'd0);
        check({tag, " row_data"}, row_data, 64'd0);
        check({tag, " busy"}, 64'(load_busy), 64'd0);
        check({tag, " done"}, 64'(load_done), 64'd0);
        check({tag, " valid"}, 64'(weights_valid), 64'd0);
        check({tag, " err"}, 64'(load_err), 64'd0);
    endtask

    // One complete load. Returns positioned in the first IDLE cycle after DONE.
    task automatic run_load(input logic [31:0] base, input int stall_pct,
                            input logic [31:0] stall_mask, input bit hold_start,
                            input bit consume_on_done, output int done_at);
        int issued;
        int wrote;
        int exp_done;
        int c;
        bit pend;
        bit en;
        bit exp_ce;
        logic [AW-1:0] a;
        load_base        = base;
        load_start       = 1'b1;
        enable           = 1'b1;
        weights_consumed = 1'b0;
        step();
        if (!hold_start) load_start = 1'b0;
        load_base = $urandom();
        issued   = 0;
        wrote    = 0;
        pend     = 1'b0;
        exp_done = -1;
        done_at  = -1;
        for (c = 1; c <= 80; c++) begin
            if (issued < ROWS) begin
                en = ($urandom_range(99) >= stall_pct);
                if (c < 32 && stall_mask[c]) en = 1'b0;
            end else begin
                en = 1'($urandom_range(1));
            end
            enable           = en;
            weights_consumed = (c == exp_done) && consume_on_done;
            #1;
            exp_ce = (issued < ROWS) && en;
            check($sformatf("wm_ce c%0d", c), 64'(wm_ce), 64'(exp_ce));
            check($sformatf("row_we c%0d", c), 64'(row_we), 64'(pend));
            check($sformatf("busy c%0d", c), 64'(load_busy), 64'd1);
            check($sformatf("done c%0d", c), 64'(load_done), 64'(c == exp_done));
            check($sformatf("valid c%0d", c), 64'(weights_valid), 64'd0);
            check($sformatf("err c%0d", c), 64'(load_err), 64'd0);
            if (exp_ce) begin
                a = base + AW'(issued);
                check($sformatf("addr c%0d", c), 64'(wm_address), 64'(a));
            end
            if (pend) begin
                a = base + AW'(wrote);
                check($sformatf("row_sel c%0d", c), 64'(row_sel), 64'(1) << wrote);
                check($sformatf("row_data c%0d", c), row_data, mem_word(a));
            end
            if (load_done) done_at = c;
            if (c == exp_done) break;
            if (pend) wrote++;
            pend = exp_ce;
            if (exp_ce) begin
                issued++;
                if (issued == ROWS) exp_done = c + 2;
            end
            step();
        end
        check("load_completed", 64'(c == exp_done), 64'd1);
        step();
        enable           = 1'b1;
        weights_consumed = 1'b0;
        #1;
        check("valid_after_done", 64'(weights_valid), 64'd1);
        check("busy_after_done", 64'(load_busy), 64'd0);
        check("done_after_done", 64'(load_done), 64'd0);
    endtask

    initial begin
        aresetn          = 1'b0;
        enable           = 1'b0;
        load_start       = 1'b0;
        load_base        = 32'd0;
        weights_consumed = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        aresetn = 1'b1;
        step();

        // Start with enable low is ignored
        load_start = 1'b1;
        load_base  = 32'h10;
        step();
        check("ignored_start_busy", 64'(load_busy), 64'd0);
        check("ignored_start_ce", 64'(wm_ce), 64'd0);
        load_start = 1'b0;
        enable     = 1'b1;
        step();

        // Basic load at base 0x10
        run_load(32'h10, 0, 32'h0, 1'b0, 1'b0, d);
        check("basic_latency", 64'(d), 64'(ROWS + 2));

        // Stall: enable low for the two cycles after the third issue
        run_load(32'h20, 0, 32'h30, 1'b0, 1'b0, d);
        check("stall_latency", 64'(d), 64'd12);

        // Consume in the DONE cycle: set wins
        run_load(32'h100, 20, 32'h0, 1'b0, 1'b1, d);
        step();
        check("consume_same_cycle_valid", 64'(weights_valid), 64'd1);

        // Consume one cycle after DONE: cleared
        run_load(32'h200, 20, 32'h0, 1'b0, 1'b0, d);
        weights_consumed = 1'b1;
        step();
        weights_consumed = 1'b0;
        check("consume_later_valid", 64'(weights_valid), 64'd0);

        // Start held through a whole load, then back-to-back accept
        run_load(32'h40, 0, 32'h0, 1'b1, 1'b0, d);
        check("hold_latency", 64'(d), 64'(ROWS + 2));
        run_load(32'h48, 0, 32'h0, 1'b0, 1'b0, d);
        check("back_to_back_latency", 64'(d), 64'(ROWS + 2));

        // Randomized bases and stalls
        for (int k = 0; k < 6; k++) begin
            run_load(32'($urandom_range(8000)), 30, 32'h0, 1'b0, 1'(k & 1), d);
        end

        // Reset in the middle of a load
        load_base  = 32'h0000_0A00;
        load_start = 1'b1;
        enable     = 1'b1;
        step();
        load_start = 1'b0;
        repeat (4) step();
        aresetn = 1'b0;
        step();
        check_all_zero("mid_reset");
        aresetn = 1'b1;
        run_load(32'h0, 0, 32'h0, 1'b0, 1'b0, d);
        check("post_reset_latency", 64'(d), 64'(ROWS + 2));

`ifdef WLOADER_BOUNDS_CHECK_EN
        // Out-of-bounds base is rejected straight to DONE
        load_base  = 32'd8190;
        load_start = 1'b1;
        enable     = 1'b1;
        step();
        load_start = 1'b0;
        check("oob_done", 64'(load_done), 64'd1);
        check("oob_err", 64'(load_err), 64'd1);
        check("oob_ce", 64'(wm_ce), 64'd0);
        check("oob_row_we", 64'(row_we), 64'd0);
        step();
        check("oob_done_after", 64'(load_done), 64'd0);
        check("oob_err_sticky", 64'(load_err), 64'd1);
        check("oob_valid", 64'(weights_valid), 64'd0);
        check("oob_busy", 64'(load_busy), 64'd0);
        check("oob_ce_after", 64'(wm_ce), 64'd0);
        // Highest in-bounds base loads normally and clears the error
        run_load(32'd8188, 0, 32'h0, 1'b0, 1'b0, d);
        check("edge_base_latency", 64'(d), 64'(ROWS + 2));
`else
        // Addresses wrap through the top of the address space
        run_load(32'hFFFF_FFFC, 25, 32'h0, 1'b0, 1'b0, d);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
